// File: rtl/dc_checkerboard.sv
// Purpose : read-back checker for the two-pass checkerboard memory test (pass A, inverted pass B).
// Latency : mismatch flagged (err_o, err_cnt_o) one cycle after the offending beat; done_o one cycle after the last pass-B beat.
// Backpressure: none; every rd_valid_i beat is consumed at once, and gaps simply hold the word index.
//
// Ports:
//   clk_i, srst_i                  clock and synchronous active-high reset
//   start_i                        arm the checker; honoured only while idle or done
//   rd_data_i / rd_valid_i         read-back word and its one-beat valid
//   busy_o / done_o / pass_o       status: checking, finished, finished with zero mismatches
//   err_o                          one-cycle pulse, previous cycle's beat mismatched
//   err_cnt_o                      total mismatches over both passes
//   first_err_pass_o/_idx_o/_data_o  location and data of the first mismatch
module dc_checkerboard #(
  parameter int WIDTH         = 8,
  parameter int LENGTH        = 512,
  parameter int INVERT_VALUES = 0
) (
  input  logic                             clk_i,
  input  logic                             srst_i,
  input  logic                             start_i,
  input  logic [WIDTH-1:0]                 rd_data_i,
  input  logic                             rd_valid_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             pass_o,
  output logic                             err_o,
  output logic [$clog2(2*LENGTH+1)-1:0]    err_cnt_o,
  output logic                             first_err_pass_o,
  output logic [$clog2(LENGTH)-1:0]        first_err_idx_o,
  output logic [WIDTH-1:0]                 first_err_data_o
);

  localparam int CNT_W = $clog2(2*LENGTH+1);
  localparam int IDX_W = $clog2(LENGTH);

  // Base pattern is defined as a 32-bit constant cut down to the word width.
  localparam logic [31:0]      BASE32 = (INVERT_VALUES != 0) ? 32'h5555_5555 : 32'haaaa_aaaa;
  localparam logic [WIDTH-1:0] BASE   = WIDTH'(BASE32);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK_A = 2'd1,
    S_CHECK_B = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx_q;

  logic             start_acc;   // start_i honoured this cycle
  logic             beat_acc;    // rd_valid_i beat consumed this cycle
  logic             pass_bit;    // 0 while in pass A, 1 while in pass B
  logic             last_beat;
  logic [WIDTH-1:0] exp_word;
  logic             mismatch;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and status decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    start_acc = 1'b0;
    beat_acc  = 1'b0;
    pass_bit  = 1'b0;
    last_beat = (idx_q == LAST);

    case (state_q)
      S_IDLE: begin
        // Beats seen while idle never reach the comparator.
        if (start_i) begin
          start_acc = 1'b1;
          state_nxt = S_CHECK_A;
        end
      end
      S_CHECK_A: begin
        busy_o   = 1'b1;
        beat_acc = rd_valid_i;
        if (rd_valid_i && last_beat) begin
          state_nxt = S_CHECK_B;
        end
      end
      S_CHECK_B: begin
        busy_o   = 1'b1;
        pass_bit = 1'b1;
        beat_acc = rd_valid_i;
        if (rd_valid_i && last_beat) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        if (start_i) begin
          start_acc = 1'b1;
          state_nxt = S_CHECK_A;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Checkerboard: even words of pass A carry BASE, and pass B swaps the phase.
  assign exp_word = (idx_q[0] ^ pass_bit) ? ~BASE : BASE;
  assign mismatch = beat_acc && (rd_data_i != exp_word);

  // done_o is already a decode of the state, so pass_o is sticky with it.
  assign pass_o = done_o && (err_cnt_o == '0);

  // ---------------------------------------------------------------------------
  // Datapath: word index, mismatch pulse/count, first-failure capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      idx_q            <= '0;
      err_o            <= 1'b0;
      err_cnt_o        <= '0;
      first_err_pass_o <= 1'b0;
      first_err_idx_o  <= '0;
      first_err_data_o <= '0;
    end else begin
      err_o <= mismatch;
      if (start_acc) begin
        idx_q            <= '0;
        err_cnt_o        <= '0;
        first_err_pass_o <= 1'b0;
        first_err_idx_o  <= '0;
        first_err_data_o <= '0;
      end else if (beat_acc) begin
        idx_q <= last_beat ? '0 : idx_q + IDX_W'(1);
        if (mismatch) begin
          err_cnt_o <= err_cnt_o + CNT_W'(1);
          // The count is still zero only for the first mismatch since start,
          // so no separate "captured" flag is needed.
          if (err_cnt_o == '0) begin
            first_err_pass_o <= pass_bit;
            first_err_idx_o  <= idx_q;
            first_err_data_o <= rd_data_i;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dc_checkerboard.sv
// Bench for dc_checkerboard: two instances (base AA and base 55) share one stimulus
// stream and are compared every cycle against a beat-count reference model.
module tb_dc_checkerboard;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int CW = $clog2(2*L+1);
  localparam int IW = $clog2(L);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         srst;
  logic         start;
  logic         valid;
  logic [W-1:0] data;

  logic [1:0]    busy, done, pass, err, fpass;
  logic [CW-1:0] cnt  [2];
  logic [IW-1:0] fidx [2];
  logic [W-1:0]  fdat [2];

  dc_checkerboard #(.WIDTH(W), .LENGTH(L), .INVERT_VALUES(0)) u_dut0 (
    .clk_i(clk), .srst_i(srst), .start_i(start), .rd_data_i(data), .rd_valid_i(valid),
    .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .err_o(err[0]),
    .err_cnt_o(cnt[0]), .first_err_pass_o(fpass[0]), .first_err_idx_o(fidx[0]),
    .first_err_data_o(fdat[0])
  );

  dc_checkerboard #(.WIDTH(W), .LENGTH(L), .INVERT_VALUES(1)) u_dut1 (
    .clk_i(clk), .srst_i(srst), .start_i(start), .rd_data_i(data), .rd_valid_i(valid),
    .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .err_o(err[1]),
    .err_cnt_o(cnt[1]), .first_err_pass_o(fpass[1]), .first_err_idx_o(fidx[1]),
    .first_err_data_o(fdat[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h want %0h", tag, m, obs, exp);
    end
  endtask

  // Reference model: per instance, how many beats have been accepted since start
  // and what has been learned from them.
  logic [W-1:0] base [2] = '{8'haa, 8'h55};
  bit           m_active [2];
  bit           m_done   [2];
  bit           m_pulse  [2];
  int           m_n      [2];
  int           m_errs   [2];
  bit           m_fpass  [2];
  int           m_fidx   [2];
  logic [W-1:0] m_fdat   [2];

  // Word expected at global beat k (0 .. 2L-1) of the two-pass stream.
  function automatic logic [W-1:0] exp_word(input int m, input int k);
    int p = k / L;
    int i = k % L;
    return ((i % 2) != p) ? ~base[m] : base[m];
  endfunction

  function automatic void model_clear(input int m);
    m_n[m] = 0; m_errs[m] = 0; m_fpass[m] = 0; m_fidx[m] = 0; m_fdat[m] = '0;
  endfunction

  function automatic void model_update(input int m);
    if (srst) begin
      m_active[m] = 0; m_done[m] = 0; m_pulse[m] = 0;
      model_clear(m);
      return;
    end
    m_pulse[m] = 0;
    if (!m_active[m]) begin
      if (start) begin
        model_clear(m);
        m_active[m] = 1;
        m_done[m]   = 0;
      end
    end else if (valid) begin
      if (data !== exp_word(m, m_n[m])) begin
        if (m_errs[m] == 0) begin
          m_fpass[m] = (m_n[m] >= L);
          m_fidx[m]  = m_n[m] % L;
          m_fdat[m]  = data;
        end
        m_errs[m]++;
        m_pulse[m] = 1;
      end
      m_n[m]++;
      if (m_n[m] == 2*L) begin
        m_active[m] = 0;
        m_done[m]   = 1;
      end
    end
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
  task automatic step(input bit s, input bit st, input bit v, input logic [W-1:0] d);
    srst = s; start = st; valid = v; data = d;
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_update(m);
    #1;
    for (int m = 0; m < 2; m++) begin
      check_eq("busy",      m, 32'(busy[m]),  32'(m_active[m]));
      check_eq("done",      m, 32'(done[m]),  32'(m_done[m]));
      check_eq("pass",      m, 32'(pass[m]),  32'(m_done[m] && m_errs[m] == 0));
      check_eq("err_pulse", m, 32'(err[m]),   32'(m_pulse[m]));
      check_eq("err_cnt",   m, 32'(cnt[m]),   32'(m_errs[m]));
      check_eq("ferr_pass", m, 32'(fpass[m]), 32'(m_fpass[m]));
      check_eq("ferr_idx",  m, 32'(fidx[m]),  32'(m_fidx[m]));
      check_eq("ferr_data", m, 32'(fdat[m]),  32'(m_fdat[m]));
    end
  endtask

  typedef logic [W-1:0] stream_t [8];

  // Start, then 8 beats with optional random gaps. A start pulse rides along with
  // beat start_at, and a reset replaces beat abort_at (-1 disables either).
  task automatic run_stream(input stream_t w, input bit gaps, input int start_at, input int abort_at);
    step(0, 1, 0, W'($urandom));
    for (int b = 0; b < 8; b++) begin
      if (b == abort_at) begin
        step(1, 0, 0, '0);
        return;
      end
      if (gaps) begin
        int ng = $urandom_range(0, 3);
        for (int g = 0; g < ng; g++) step(0, 0, 0, W'($urandom));
      end
      step(0, b == start_at, 1, w[b]);
    end
    step(0, 0, 1, W'($urandom));   // beat in DONE: ignored
    step(0, 0, 0, '0);
  endtask

  stream_t t_clean = '{8'haa, 8'h55, 8'haa, 8'h55, 8'h55, 8'haa, 8'h55, 8'haa};
  stream_t t_bad   = '{8'haa, 8'h55, 8'haa, 8'h55, 8'h55, 8'haa, 8'h00, 8'haa};
  stream_t t_inv   = '{8'h55, 8'haa, 8'h55, 8'haa, 8'haa, 8'h55, 8'haa, 8'h55};
  stream_t t_one   = '{8'haa, 8'h55, 8'h12, 8'h55, 8'h55, 8'haa, 8'h55, 8'haa};
  stream_t t_rnd;

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_active[m] = 0; m_done[m] = 0; m_pulse[m] = 0;
      model_clear(m);
    end
    srst = 1; start = 0; valid = 0; data = '0;
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    for (int m = 0; m < 2; m++) begin
      check_eq("rst_busy", m, 32'(busy[m]), 0);
      check_eq("rst_cnt",  m, 32'(cnt[m]),  0);
    end

    // Beats in IDLE before any start must not count.
    for (int b = 0; b < 4; b++) step(0, 0, 1, W'($urandom));
    check_eq("idle_cnt", 0, 32'(cnt[0]), 0);

    // Clean pass for base AA.
    run_stream(t_clean, 0, -1, -1);
    check_eq("t1_pass", 0, 32'(pass[0]), 1);
    check_eq("t1_cnt",  0, 32'(cnt[0]),  0);

    // Single bad word at pass B index 2.
    run_stream(t_bad, 0, -1, -1);
    check_eq("t2_cnt",   0, 32'(cnt[0]),   1);
    check_eq("t2_fpass", 0, 32'(fpass[0]), 1);
    check_eq("t2_fidx",  0, 32'(fidx[0]),  2);
    check_eq("t2_fdat",  0, 32'(fdat[0]),  0);
    check_eq("t2_pass",  0, 32'(pass[0]),  0);

    // Base-55 stream with gaps: clean for dut1, fully inverted for dut0.
    run_stream(t_inv, 1, -1, -1);
    check_eq("t3_pass",  1, 32'(pass[1]),  1);
    check_eq("t4_cnt",   0, 32'(cnt[0]),   8);
    check_eq("t4_fpass", 0, 32'(fpass[0]), 0);
    check_eq("t4_fidx",  0, 32'(fidx[0]),  0);
    check_eq("t4_fdat",  0, 32'(fdat[0]),  8'h55);

    // start_i while busy is ignored.
    run_stream(t_clean, 0, 3, -1);
    check_eq("t5_pass", 0, 32'(pass[0]), 1);
    check_eq("t5_cnt",  0, 32'(cnt[0]),  0);

    // Reset after 5 beats containing one error, then a clean run.
    run_stream(t_one, 0, -1, 5);
    check_eq("t6_busy", 0, 32'(busy[0]), 0);
    check_eq("t6_cnt",  0, 32'(cnt[0]),  0);
    check_eq("t6_fdat", 0, 32'(fdat[0]), 0);
    step(0, 0, 0, '0);
    run_stream(t_clean, 1, -1, -1);
    check_eq("t6_pass", 0, 32'(pass[0]), 1);

    // Randomized runs: mostly-correct words for a random base, random corruption,
    // gaps, stray start pulses and occasional aborts.
    for (int r = 0; r < 40; r++) begin
      int sel = $urandom_range(0, 1);
      for (int b = 0; b < 8; b++)
        t_rnd[b] = ($urandom_range(0, 3) == 0) ? W'($urandom) : exp_word(sel, b);
      run_stream(t_rnd, $urandom_range(0, 1) == 1, $urandom_range(0, 9),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(0, 0, $urandom_range(0, 1) == 1, W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
